// File: rtl/iq_upconverter_mixer.sv
// IQ upconverter mixer.
// Holds one baseband symbol for a programmable number of samples and mixes it
// against the quadrature carrier as I*cos - Q*sin. The product is rounded and
// saturated to the output width in a three-stage pipeline.
//
// state | meaning
// IDLE  | no symbol held, symbol regs cleared
// RUN   | symbol held, r_cnt = uses remaining after the current one
//
// The output shift S = OW+BW-DW must be at least 1.
module iq_upconverter_mixer #(
    parameter int OW = 16,
    parameter int BW = 12,
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic signed [OW-1:0] i_carrier_i,
    input  logic signed [OW-1:0] i_carrier_q,
    input  logic                 i_bb_valid,
    output logic                 o_bb_ready,
    input  logic signed [BW-1:0] i_bb_i,
    input  logic signed [BW-1:0] i_bb_q,
    input  logic        [CW-1:0] i_sps_m1,
    output logic signed [DW-1:0] o_val,
    output logic                 o_valid,
    output logic                 o_underrun
);
    localparam int PW = OW + BW;
    localparam int S  = OW + BW - DW;
    localparam int RW = PW + 2;
    localparam logic [RW-1:0] ROUND = {{(RW-1){1'b0}}, 1'b1} << (S - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               r_state;
    logic        [CW-1:0] r_cnt;
    logic signed [BW-1:0] r_sym_i;
    logic signed [BW-1:0] r_sym_q;
    logic signed [PW-1:0] r_p_i;
    logic signed [PW-1:0] r_p_q;
    logic                 r_v1;
    logic signed [PW:0]   r_d;
    logic                 r_v2;

    logic                 w_xfer;
    logic signed [PW-1:0] w_sym_i_ext;
    logic signed [PW-1:0] w_sym_q_ext;
    logic signed [PW-1:0] w_car_i_ext;
    logic signed [PW-1:0] w_car_q_ext;
    logic signed [PW:0]   w_diff;
    logic signed [RW-1:0] w_sum;
    logic signed [RW-1:0] w_shift;
    logic                 w_fits;
    logic signed [DW-1:0] w_sat;

    assign o_bb_ready = i_ce & ((r_state == IDLE) | (r_cnt == '0));
    assign w_xfer     = i_bb_valid & o_bb_ready;

    // Operands widened to the product width so the multiply is exact.
    assign w_sym_i_ext = {{(PW-BW){r_sym_i[BW-1]}}, r_sym_i};
    assign w_sym_q_ext = {{(PW-BW){r_sym_q[BW-1]}}, r_sym_q};
    assign w_car_i_ext = {{(PW-OW){i_carrier_i[OW-1]}}, i_carrier_i};
    assign w_car_q_ext = {{(PW-OW){i_carrier_q[OW-1]}}, i_carrier_q};

    // One extra bit keeps the I-Q difference exact.
    assign w_diff = {r_p_i[PW-1], r_p_i} - {r_p_q[PW-1], r_p_q};

    // Round half up, arithmetic shift, then clamp if the upper bits disagree.
    assign w_sum   = {r_d[PW], r_d} + ROUND;
    assign w_shift = w_sum >>> S;
    assign w_fits  = (&w_shift[RW-1:DW-1]) | ~(|w_shift[RW-1:DW-1]);
    assign w_sat   = w_fits ? w_shift[DW-1:0]
                   : (w_shift[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

    // Symbol hold FSM: load on transfer, count down uses, drop to IDLE with an underrun pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sym_i    <= '0;
            r_sym_q    <= '0;
            o_underrun <= 1'b0;
        end else if (i_ce) begin
            o_underrun <= 1'b0;
            if (w_xfer) begin
                r_state <= RUN;
                r_cnt   <= i_sps_m1;
                r_sym_i <= i_bb_i;
                r_sym_q <= i_bb_q;
            end else if (r_state == RUN) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    r_state    <= IDLE;
                    r_sym_i    <= '0;
                    r_sym_q    <= '0;
                    o_underrun <= 1'b1;
                end
            end
        end
    end

    // Mixer pipeline: products, difference, round/saturate, with valid alongside.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_p_i   <= '0;
            r_p_q   <= '0;
            r_v1    <= 1'b0;
            r_d     <= '0;
            r_v2    <= 1'b0;
            o_val   <= '0;
            o_valid <= 1'b0;
        end else if (i_ce) begin
            r_p_i   <= w_sym_i_ext * w_car_i_ext;
            r_p_q   <= w_sym_q_ext * w_car_q_ext;
            r_v1    <= (r_state == RUN);
            r_d     <= w_diff;
            r_v2    <= r_v1;
            o_val   <= w_sat;
            o_valid <= r_v2;
        end
    end
endmodule

// File: doc/iq_upconverter_mixer.md
IQ_UPCONVERTER_MIXER -- requirements
Module: iq_upconverter_mixer

Interface
REQ-001 SHALL have parameter OW, default 16, carrier sample width (signed).
REQ-002 SHALL have parameter BW, default 12, baseband sample width (signed).
REQ-003 SHALL have parameter DW, default 16, output sample width (signed). Shift S = OW+BW-DW; S >= 1 required.
REQ-004 SHALL have parameter CW, default 8, symbol-length counter width.
REQ-005 i_clk  input  1  clock; all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_ce  input  1  clock enable; state advances only on edges where i_ce=1 (a "ce cycle").
REQ-008 i_carrier_i  input  OW  signed cosine carrier sample from the sine lookup stage.
REQ-009 i_carrier_q  input  OW  signed sine carrier sample from the sine lookup stage.
REQ-010 i_bb_valid  input  1  baseband symbol available.
REQ-011 o_bb_ready  output  1  block accepts a symbol this cycle.
REQ-012 i_bb_i, i_bb_q  input  BW each  signed baseband I/Q symbol.
REQ-013 i_sps_m1  input  CW  samples per symbol minus one, sampled at symbol transfer.
REQ-014 o_val  output  DW  signed modulated sample.
REQ-015 o_valid  output  1  o_val carries a sample from a held symbol.
REQ-016 o_underrun  output  1  underrun indication, one ce cycle wide.

Function
REQ-017 SHALL use a two-state FSM: IDLE (no symbol held, symbol regs = 0) and RUN (symbol held, counter cnt active).
REQ-018 o_bb_ready SHALL equal i_ce AND (state==IDLE OR cnt==0), combinational from registers and i_ce.
REQ-019 Transfer SHALL occur on a ce cycle with i_bb_valid=1 and o_bb_ready=1: sym_i/sym_q <= i_bb_i/i_bb_q, cnt <= i_sps_m1, state <= RUN.
REQ-020 In RUN on a ce cycle with cnt!=0: cnt <= cnt-1; symbol held.
REQ-021 In RUN on a ce cycle with cnt==0 and no transfer: state <= IDLE, symbol regs <= 0, o_underrun <= 1 for one ce cycle (else 0).
REQ-022 In IDLE with no transfer: no underrun; state stays IDLE.
REQ-023 Each ce cycle, stage 1 SHALL register p_i = sym_i*i_carrier_i and p_q = sym_q*i_carrier_q (OW+BW bits) using pre-update symbol regs, and v1 = (state==RUN); a symbol transferred on ce cycle k is first used on ce cycle k+1 and used for exactly i_sps_m1+1 ce cycles.
REQ-024 Stage 2 SHALL register d = p_i - p_q at OW+BW+1 bits, no overflow.
REQ-025 Stage 3 SHALL register o_val = saturate_DW((d + 2^(S-1)) >>> S), clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-026 o_valid SHALL be v1 delayed through stages 2 and 3; latency = 3 ce cycles from use to o_val.
REQ-027 With i_ce=0 all registers SHALL hold and o_bb_ready SHALL be 0.
REQ-028 Simultaneous cnt==0 and transfer SHALL load the new symbol with no gap and no underrun.

Reset
REQ-029 While i_reset=1: state IDLE, cnt=0, symbol regs, all pipeline regs, o_val=0, o_valid=0, o_underrun=0, immediately and asynchronously.
REQ-030 Reset mid-symbol SHALL discard held symbol and in-flight samples; no underrun pulse after release.

Verification
REQ-031 Reset, then i_ce=1, i_bb_valid=0 -> o_val=0, o_valid=0, o_underrun=0, o_bb_ready=1.
REQ-032 i_sps_m1=3, symbol (2047,0), carrier (32767,0) -> o_val=16376, o_valid=1 for exactly 4 ce cycles, first 3 ce cycles after first use; o_bb_ready=1 on the 4th use cycle only.
REQ-033 Symbol (-2048,-2048), carrier (-32768,32767) -> o_val=32767 (saturated).
REQ-034 i_sps_m1=1, one symbol then i_bb_valid=0 -> o_underrun=1 for one ce cycle after 2nd use, o_valid drops 3 ce cycles later, o_val returns to 0.
REQ-035 i_sps_m1=0, i_bb_valid held 1, distinct symbols each cycle -> o_bb_ready=1 every ce cycle, one output per symbol in order, no underrun.
REQ-036 i_ce toggled 1/0 mid-symbol -> outputs and cnt frozen on i_ce=0 cycles; i_reset pulse mid-symbol -> all outputs 0 at once, FSM IDLE.
